// File: rtl/apb_stream_mem_pair.sv
// ---------------------------------------------------------------------------
// apb_stream_mem_pair
//
// Two APB-mapped word memories joined by an internal AXI-Stream link.
//   * Input memory: loaded over the in_* APB port. A rising edge on send_start
//     streams words 0..send_length-1 out as one AXIS frame.
//   * Output memory: captures every beat of that frame (tready is always 1)
//     and exposes the captured words on the out_* APB port.
// The AXIS link is exported read-only for monitoring.
//
// Ports
//   clk, rstn             clock, asynchronous active-high reset
//   in_p*                 APB slave for the input memory (word index = paddr[AW+1:2])
//   out_p*                APB slave for the output memory (writes are accepted, ignored)
//   send_start            frame request, rising-edge sensitive
//   send_length           words per frame (0 = no frame)
//   axis_t*               internal link monitor
//   stream_busy           frame being sent
//   frame_done            one-cycle pulse after the tlast beat is captured
// ---------------------------------------------------------------------------
module apb_stream_mem_pair #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    output logic [31:0] in_prdata,
    output logic        in_pready,
    output logic        in_pslverr,

    input  logic [31:0] out_paddr,
    input  logic        out_psel,
    input  logic        out_penable,
    input  logic        out_pwrite,
    input  logic [31:0] out_pwdata,
    output logic [31:0] out_prdata,
    output logic        out_pready,
    output logic        out_pslverr,

    input  logic        send_start,
    input  logic [11:0] send_length,

    output logic [31:0] axis_tdata,
    output logic        axis_tvalid,
    output logic [3:0]  axis_tkeep,
    output logic        axis_tlast,
    output logic        axis_tready,

    output logic        stream_busy,
    output logic        frame_done
);

    localparam int LW = 12;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    // -----------------------------------------------------------------------
    // Storage (contents are never reset)
    // -----------------------------------------------------------------------
    logic [31:0] in_mem_q  [DEPTH];
    logic [31:0] out_mem_q [DEPTH];

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    state_t        state_q,       state_d;
    logic [LW-1:0] len_q,         len_d;
    logic [LW-1:0] cnt_q,         cnt_d;
    logic [AW-1:0] rd_ptr_q,      rd_ptr_d;
    logic [31:0]   tdata_q,       tdata_d;
    logic          start_q,       start_d;
    logic          tready_q,      tready_d;
    logic [AW-1:0] wr_ptr_q,      wr_ptr_d;
    logic          frame_done_q,  frame_done_d;
    logic          in_pready_q,   in_pready_d;
    logic [31:0]   in_prdata_q,   in_prdata_d;
    logic          out_pready_q,  out_pready_d;
    logic [31:0]   out_prdata_q,  out_prdata_d;

    // -----------------------------------------------------------------------
    // Combinational helpers
    // -----------------------------------------------------------------------
    logic [AW-1:0] in_idx, out_idx;
    logic          in_access, out_access;
    logic          in_we;
    logic          start_edge;
    logic          tvalid, tlast, beat;
    logic          fetch_en;
    logic [AW-1:0] fetch_addr;
    logic [31:0]   fetch_word;

    assign in_idx     = in_paddr[AW+1:2];
    assign out_idx    = out_paddr[AW+1:2];
    assign in_access  = in_psel & in_penable;
    assign out_access = out_psel & out_penable;

    // Writes land on the cycle pready is high, i.e. the completing edge.
    assign in_we      = in_access & in_pwrite & in_pready_q;

    assign start_edge = send_start & ~start_q;

    assign tvalid     = (state_q == S_STREAM);
    assign tlast      = tvalid & (cnt_q == len_q - LW'(1));
    assign beat       = tvalid & tready_q;

    // Prefetch path: the next word is read while the current one is on the
    // link. A same-cycle APB write to that word is forwarded so the frame
    // always carries the newest value of words not yet presented.
    assign fetch_word = (in_we && (in_idx == fetch_addr)) ? in_pwdata
                                                          : in_mem_q[fetch_addr];

    // Address bits outside the word index and output-side write data are
    // intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^{in_paddr[31:AW+2], in_paddr[1:0],
                         out_paddr[31:AW+2], out_paddr[1:0], out_pwdata};

    // -----------------------------------------------------------------------
    // Input-side FSM: next state / outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        rd_ptr_d   = rd_ptr_q;
        fetch_en   = 1'b0;
        fetch_addr = rd_ptr_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    len_d = send_length;
                    if (send_length != '0) begin
                        rd_ptr_d   = '0;
                        cnt_d      = '0;
                        fetch_en   = 1'b1;
                        fetch_addr = '0;
                        state_d    = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                if (beat) begin
                    if (tlast) begin
                        rd_ptr_d = '0;
                        cnt_d    = '0;
                        state_d  = S_IDLE;
                    end else begin
                        // rd_ptr wraps modulo DEPTH by width.
                        rd_ptr_d   = rd_ptr_q + AW'(1);
                        cnt_d      = cnt_q + LW'(1);
                        fetch_en   = 1'b1;
                        fetch_addr = rd_ptr_q + AW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // tdata only changes on a beat or frame start, so it is stable whenever
    // tvalid & ~tready.
    always_comb begin
        tdata_d = tdata_q;
        if (fetch_en) begin
            tdata_d = fetch_word;
        end
    end

    always_comb begin
        start_d  = send_start;
        tready_d = 1'b1;
    end

    // -----------------------------------------------------------------------
    // Output-side capture
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        frame_done_d = 1'b0;
        if (beat) begin
            if (tlast) begin
                wr_ptr_d     = '0;
                frame_done_d = 1'b1;
            end else begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // APB slaves: one wait state, pready a single-cycle pulse
    // -----------------------------------------------------------------------
    always_comb begin
        in_pready_d = in_access & ~in_pready_q;
        in_prdata_d = in_prdata_q;
        if (in_access && !in_pready_q && !in_pwrite) begin
            in_prdata_d = in_mem_q[in_idx];
        end
    end

    always_comb begin
        out_pready_d = out_access & ~out_pready_q;
        out_prdata_d = out_prdata_q;
        if (out_access && !out_pready_q && !out_pwrite) begin
            out_prdata_d = out_mem_q[out_idx];
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            rd_ptr_q     <= '0;
            tdata_q      <= '0;
            start_q      <= 1'b0;
            tready_q     <= 1'b0;
            wr_ptr_q     <= '0;
            frame_done_q <= 1'b0;
            in_pready_q  <= 1'b0;
            in_prdata_q  <= '0;
            out_pready_q <= 1'b0;
            out_prdata_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            tdata_q      <= tdata_d;
            start_q      <= start_d;
            tready_q     <= tready_d;
            wr_ptr_q     <= wr_ptr_d;
            frame_done_q <= frame_done_d;
            in_pready_q  <= in_pready_d;
            in_prdata_q  <= in_prdata_d;
            out_pready_q <= out_pready_d;
            out_prdata_q <= out_prdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_we) begin
            in_mem_q[in_idx] <= in_pwdata;
        end
    end

    // Capture has priority over nothing else on this port; an APB read of
    // the same word this cycle may see either old or new data.
    always_ff @(posedge clk) begin
        if (beat) begin
            out_mem_q[wr_ptr_q] <= tdata_q;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign in_prdata   = in_prdata_q;
    assign in_pready   = in_pready_q;
    assign in_pslverr  = 1'b0;
    assign out_prdata  = out_prdata_q;
    assign out_pready  = out_pready_q;
    assign out_pslverr = 1'b0;

    assign axis_tdata  = tdata_q;
    assign axis_tvalid = tvalid;
    assign axis_tkeep  = tvalid ? 4'hF : 4'h0;
    assign axis_tlast  = tlast;
    assign axis_tready = tready_q;

    assign stream_busy = tvalid;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_apb_stream_mem_pair.sv
module tb_apb_stream_mem_pair;

    localparam int DEPTH = 4096;
    localparam int AW    = 12;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] in_paddr, in_pwdata, in_prdata;
    logic        in_psel, in_penable, in_pwrite, in_pready, in_pslverr;
    logic [31:0] out_paddr, out_pwdata, out_prdata;
    logic        out_psel, out_penable, out_pwrite, out_pready, out_pslverr;
    logic        send_start;
    logic [11:0] send_length;
    logic [31:0] axis_tdata;
    logic        axis_tvalid, axis_tlast, axis_tready;
    logic [3:0]  axis_tkeep;
    logic        stream_busy, frame_done;

    always #5 clk = ~clk;

    apb_stream_mem_pair #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
        .in_pwrite(in_pwrite), .in_pwdata(in_pwdata), .in_prdata(in_prdata),
        .in_pready(in_pready), .in_pslverr(in_pslverr),
        .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
        .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_prdata(out_prdata),
        .out_pready(out_pready), .out_pslverr(out_pslverr),
        .send_start(send_start), .send_length(send_length),
        .axis_tdata(axis_tdata), .axis_tvalid(axis_tvalid), .axis_tkeep(axis_tkeep),
        .axis_tlast(axis_tlast), .axis_tready(axis_tready),
        .stream_busy(stream_busy), .frame_done(frame_done)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    int          n_chk = 0;
    int          n_fail = 0;
    beat_t       exp_q[$];
    beat_t       mon_e;
    logic [31:0] model_in  [0:63];
    logic [31:0] exp_out   [0:63];
    int          cyc = 0;
    int          beat_cnt = 0, done_cnt = 0;
    int          beat_base = 0, done_base = 0;
    int          first_cyc = 0, last_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input int i);
        logic [5:0] b;
        b = i[5:0];
        return {b, 2'b11, b, 2'b10, b, 2'b01, b, 2'b00};
    endfunction

    // Link monitor: every transferred beat is checked against the scoreboard.
    always @(negedge clk) begin
        if (axis_tvalid && axis_tready) begin
            chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("tdata", axis_tdata, mon_e.data);
                chk("tlast", 32'(axis_tlast), 32'(mon_e.last));
                chk("tkeep", 32'(axis_tkeep), 32'hF);
            end
            if (beat_cnt == beat_base) first_cyc = cyc;
            last_cyc = cyc;
            beat_cnt++;
        end
        if (frame_done) done_cnt++;
    end

    task automatic apb(input bit outp, input bit wr, input int idx,
                       input logic [31:0] wd, output logic [31:0] rd, output int lat);
        logic [31:0] a;
        logic        rdy;
        a = $urandom();
        a[AW+1:2] = idx[AW-1:0];
        @(negedge clk);
        if (outp) begin
            out_paddr = a; out_pwrite = wr; out_pwdata = wd; out_psel = 1'b1; out_penable = 1'b0;
        end else begin
            in_paddr = a; in_pwrite = wr; in_pwdata = wd; in_psel = 1'b1; in_penable = 1'b0;
        end
        @(negedge clk);
        if (outp) out_penable = 1'b1; else in_penable = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            rdy = outp ? out_pready : in_pready;
        end while (!rdy && lat < 8);
        chk("apb_pready", 32'(rdy), 32'd1);
        chk("apb_pslverr", 32'(outp ? out_pslverr : in_pslverr), 32'd0);
        rd = outp ? out_prdata : in_prdata;
        @(negedge clk);
        if (outp) begin out_psel = 1'b0; out_penable = 1'b0; end
        else      begin in_psel  = 1'b0; in_penable  = 1'b0; end
        chk("apb_pready_pulse", 32'(outp ? out_pready : in_pready), 32'd0);
        if (!outp && wr && idx < 64) model_in[idx] = wd;
    endtask

    // Pushes the expected frame, raises send_start and checks busy follows.
    task automatic start_frame(input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = model_in[i];
            b.last = (i == len - 1);
            exp_q.push_back(b);
            exp_out[i] = model_in[i];
        end
        beat_base   = beat_cnt;
        done_base   = done_cnt;
        send_length = 12'(len);
        send_start  = 1'b1;
        @(negedge clk);
        chk("stream_busy_on", 32'(stream_busy), 32'd1);
    endtask

    task automatic wait_frame(input int len);
        int t;
        t = 0;
        while (done_cnt == done_base && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("frame_done_pulses", 32'(done_cnt - done_base), 32'd1);
        chk("beat_count", 32'(beat_cnt - beat_base), 32'(len));
        chk("beats_consecutive", 32'(last_cyc - first_cyc), 32'(len - 1));
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("stream_busy_off", 32'(stream_busy), 32'd0);
    endtask

    task automatic check_out(input int n);
        logic [31:0] rd;
        int lat;
        for (int i = 0; i < n; i++) begin
            apb(1'b1, 1'b0, i, 32'h0, rd, lat);
            chk($sformatf("out_mem[%0d]", i), rd, exp_out[i]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int lat, t;
        bit busy_seen;

        rstn = 1'b1;
        in_paddr = '0; in_psel = 0; in_penable = 0; in_pwrite = 0; in_pwdata = '0;
        out_paddr = '0; out_psel = 0; out_penable = 0; out_pwrite = 0; out_pwdata = '0;
        send_start = 1'b0; send_length = '0;
        for (int i = 0; i < 64; i++) begin model_in[i] = 'x; exp_out[i] = 'x; end

        // Reset state
        @(negedge clk);
        chk("rst_tvalid", 32'(axis_tvalid), 0);
        chk("rst_tready", 32'(axis_tready), 0);
        chk("rst_tdata", axis_tdata, 0);
        chk("rst_tkeep", 32'(axis_tkeep), 0);
        chk("rst_tlast", 32'(axis_tlast), 0);
        chk("rst_busy", 32'(stream_busy), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        chk("rst_in_pready", 32'(in_pready), 0);
        chk("rst_in_prdata", in_prdata, 0);
        chk("rst_out_pready", 32'(out_pready), 0);
        chk("rst_out_prdata", out_prdata, 0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("tready_after_reset", 32'(axis_tready), 1);

        // Load 20 words, then handshake/readback of index 5
        for (int i = 0; i < 20; i++) apb(1'b0, 1'b1, i, word(i), rd, lat);
        apb(1'b0, 1'b0, 5, 32'h0, rd, lat);
        chk("in_read_latency", 32'(lat), 1);
        chk("in_read_idx5", rd, 32'h17161514);
        apb(1'b0, 1'b0, 19, 32'h0, rd, lat);
        chk("in_read_idx19", rd, 32'h4F4E4D4C);

        // Load and stream, start held high 10 cycles
        start_frame(20);
        repeat (9) @(negedge clk);
        send_start = 1'b0;
        wait_frame(20);
        check_out(20);

        // Output-memory writes complete without effect
        apb(1'b1, 1'b1, 2, 32'hCAFEF00D, rd, lat);
        chk("out_write_latency", 32'(lat), 1);
        check_out(3);

        // Zero length
        beat_base = beat_cnt;
        busy_seen = 1'b0;
        send_length = 12'd0;
        send_start  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            busy_seen = busy_seen | stream_busy | axis_tvalid;
            if (i == 2) send_start = 1'b0;
        end
        chk("zero_len_busy", 32'(busy_seen), 0);
        chk("zero_len_beats", 32'(beat_cnt - beat_base), 0);

        // Retrigger mid-frame is ignored
        start_frame(20);
        @(negedge clk);
        send_start = 1'b0;
        t = 0;
        while ((beat_cnt - beat_base) < 5 && t < 50) begin @(negedge clk); t++; end
        send_start = 1'b1;
        repeat (2) @(negedge clk);
        send_start = 1'b0;
        wait_frame(20);

        // New frame after idle overwrites output memory from index 0
        for (int i = 0; i < 3; i++) apb(1'b0, 1'b1, i, ~word(i), rd, lat);
        start_frame(3);
        send_start = 1'b0;
        wait_frame(3);
        check_out(4);

        // Length 1
        apb(1'b0, 1'b1, 0, 32'hDEADBEEF, rd, lat);
        start_frame(1);
        send_start = 1'b0;
        wait_frame(1);
        check_out(1);

        // Reset mid-stream
        start_frame(20);
        send_start = 1'b0;
        t = 0;
        while ((beat_cnt - beat_base) < 7 && t < 50) begin @(negedge clk); t++; end
        chk("reached_beat7", 32'((beat_cnt - beat_base) >= 7), 1);
        #2 rstn = 1'b1;
        #1;
        chk("midrst_tvalid", 32'(axis_tvalid), 0);
        chk("midrst_busy", 32'(stream_busy), 0);
        chk("midrst_tready", 32'(axis_tready), 0);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("tready_after_midrst", 32'(axis_tready), 1);
        for (int i = 0; i < 4; i++) apb(1'b0, 1'b1, i, 32'hA5000000 | 32'(i), rd, lat);
        start_frame(4);
        send_start = 1'b0;
        wait_frame(4);
        check_out(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_stream_mem_pair.md
Name: apb_stream_mem_pair

Overview:
- Pair of APB-mapped word memories joined by an internal AXI-Stream link.
- Input memory: software loads words over APB, then a start request streams words 0..N-1 out as one AXIS frame.
- Output memory: captures that frame beat by beat and exposes it for APB readback.
- Sits as a loopback or data-path harness around an offline-computed data set; the AXIS link is also exported for monitoring.

Parameters:
- DEPTH, 4096, words per memory (power of two).
- AW, 12, word-index width, log2(DEPTH).

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- in_paddr  in  32  input-mem APB address; word index = in_paddr[AW+1:2], other bits ignored
- in_psel, in_penable, in_pwrite  in  1 each  input-mem APB controls
- in_pwdata  in  32  write data
- in_prdata  out  32  read data
- in_pready  out  1  transfer complete
- in_pslverr  out  1  always 0
- out_paddr, out_psel, out_penable, out_pwrite, out_pwdata, out_prdata, out_pready, out_pslverr: same roles for the output memory
- send_start  in  1  stream request, rising-edge sensitive
- send_length  in  12  words per frame
- axis_tdata  out  32  link monitor
- axis_tvalid  out  1  link monitor
- axis_tkeep  out  4  link monitor
- axis_tlast  out  1  link monitor
- axis_tready  out  1  link monitor
- stream_busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when the output side captures tlast

Behaviour:
- Reset and clock: reset rstn, asynchronous, active-high; clock clk. All logic is on the clk rising edge.
- Reset values: all outputs 0 except axis_tready (1 after reset release). Pointers 0, FSM IDLE. Memory contents are not reset.
- APB slave (each port independent):
  - Access cycle = psel & penable.
  - pready is registered: pready <= psel & penable & ~pready. This gives one wait state and a one-cycle pulse; if psel is held, the transfer repeats every other cycle, which is harmless.
  - Write commits to mem[index] on the cycle pready=1 with pwrite=1.
  - Read: prdata is registered, valid while pready=1, and held afterwards.
  - Writes to the output memory complete (pready) with no effect.
  - pslverr is always 0.
  - Neither port checks the penable-without-psel setup phase.
- Input side FSM:
  - IDLE: on a send_start rising edge (registered edge detect), latch len = send_length.
    - If len = 0: stay IDLE.
    - Otherwise: rd_ptr = 0, go to STREAM.
  - STREAM:
    - tvalid=1, tdata = mem[rd_ptr], tkeep = 4'hF, tlast = (rd_ptr == len-1).
    - A beat transfers on tvalid & tready, then rd_ptr++.
    - After the beat with tlast, go to IDLE next cycle and drop tvalid.
  - Throughput: one beat per cycle while tready=1. tdata must be stable while tvalid & ~tready. RAM read latency is hidden by prefetch.
  - stream_busy = (state == STREAM).
  - Start edges during STREAM are ignored.
  - len > DEPTH: rd_ptr wraps modulo DEPTH.
  - APB writes during STREAM are allowed; a word not yet sent shows its new value.
- Output side:
  - tready = 1 always (capture never stalls).
  - Each beat writes tdata to mem[wr_ptr], then wr_ptr++ modulo DEPTH. tkeep is ignored (whole word stored).
  - The tlast beat is stored, then wr_ptr <= 0 and frame_done pulses.
  - APB read and capture on the same cycle: capture write wins; the read returns old or new data (unspecified).
- Reset mid-frame: both sides return to IDLE with pointers 0. A partially captured frame remains in the output memory.

Test Plan:
- Load and stream: APB-write 20 words, word i = {i[5:0],2'b11,i[5:0],2'b10,i[5:0],2'b01,i[5:0],2'b00} (i=0 → 0x03020100, i=1 → 0x07060504, i=19 → 0x4F4E4D4C). Set send_length=20, hold send_start high 10 cycles -> exactly 20 consecutive tvalid beats with matching data, tkeep=F, tlast only on beat 19, a single frame_done pulse, and out-mem reads of 0..19 returning the same words.
- APB handshake: single write, then read of in-mem index 5 -> pready is a one-cycle pulse one cycle after psel&penable; prdata = 0x17161514; pslverr = 0.
- Zero length: send_length=0 with a start edge -> no tvalid, stream_busy stays 0.
- Retrigger ignored: second start edge mid-frame of length 20 -> still exactly 20 beats. A new edge after idle -> new frame overwrites out-mem from index 0.
- Length 1: single beat with tvalid and tlast together -> out-mem[0] updated, frame_done pulses.
- Reset mid-stream: assert rstn at beat 7 -> tvalid=0 immediately. After release, a new frame restarts at index 0.
